// File: rtl/mfsk_modulator_if.sv
// Symbol stream handshake between the framer/bit-packer and the MFSK modulator.
`timescale 1ns/1ps
interface mfsk_modulator_if #(
  parameter int unsigned BITS_PER_SYM = 2
) ();
  logic [BITS_PER_SYM-1:0] sym_data;
  logic                    sym_valid;
  logic                    sym_ready;

  // Producer side: drives symbols, observes acceptance.
  modport master (
    output sym_data,
    output sym_valid,
    input  sym_ready
  );

  // Modulator side: consumes symbols, signals acceptance.
  modport slave (
    input  sym_data,
    input  sym_valid,
    output sym_ready
  );
endinterface

// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: each accepted K-bit symbol selects a square-wave
// half-period N(s) = HP_BASE + s*HP_STEP and is held for SYM_LEN cycles.
// The half-period counter is never reset between back-to-back symbols, so
// the output waveform stays phase-continuous across tone changes.
`timescale 1ns/1ps
module mfsk_modulator #(
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned HP_BASE      = 15,
  parameter int unsigned HP_STEP      = 16,
  parameter int unsigned SYM_LEN      = 1024,
  parameter int unsigned CNT_W        = 20
) (
  input  logic            clk,
  input  logic            as_reset_n,
  input  logic            enable,
  input  logic            underrun_clr,
  mfsk_modulator_if.slave sym_if,
  output logic            fsk_output,
  output logic            busy,
  output logic            underrun
);

  localparam int unsigned NUM_TONES = 1 << BITS_PER_SYM;
  localparam int unsigned SC_W      = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [63:0] MAX_N     = 64'(HP_BASE) + 64'(NUM_TONES - 1) * 64'(HP_STEP);
  localparam logic [63:0] CNT_LIM   = 64'(1) << CNT_W;

  // Refuse to build parameter sets that would produce a zero or wrapped half-period.
  if (HP_BASE < 1) begin : g_bad_base
    $error("mfsk_modulator: HP_BASE must be at least 1");
  end
  if (MAX_N >= CNT_LIM) begin : g_bad_cnt_w
    $error("mfsk_modulator: CNT_W too narrow for the largest half-period");
  end
  if (SYM_LEN < 2) begin : g_bad_sym_len
    $error("mfsk_modulator: SYM_LEN must be at least 2");
  end

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [SC_W-1:0]         sc_q, sc_d;
  logic [CNT_W-1:0]        hc_q, hc_d;
  logic [BITS_PER_SYM-1:0] cur_sym_q, cur_sym_d;
  logic                    fsk_q, fsk_d;
  logic                    busy_q, busy_d;
  logic                    underrun_q, underrun_d;

  logic                    sym_last_c;
  logic                    sym_ready_c;
  logic                    accept_c;
  logic [CNT_W-1:0]        half_lim_c;
  logic                    set_underrun_c;

  // Last cycle of the current symbol; the only ACTIVE cycle a new symbol may be taken.
  assign sym_last_c = (sc_q == SC_W'(SYM_LEN - 1));

  // Acceptance window; forced low while reset is held.
  always_comb begin
    sym_ready_c = 1'b0;
    if (as_reset_n && enable) begin
      case (state_q)
        ST_IDLE:   sym_ready_c = 1'b1;
        ST_ACTIVE: sym_ready_c = sym_last_c;
        default:   sym_ready_c = 1'b0;
      endcase
    end
  end

  assign sym_if.sym_ready = sym_ready_c;
  assign accept_c         = sym_if.sym_valid & sym_ready_c;

  // Terminal count of the half-period counter for the current tone, N(s)-1.
  assign half_lim_c = CNT_W'(HP_BASE) + CNT_W'(cur_sym_q) * CNT_W'(HP_STEP) - CNT_W'(1);

  // Next-state, counters, tone output and sticky underrun.
  always_comb begin
    state_d        = state_q;
    sc_d           = sc_q;
    hc_d           = hc_q;
    cur_sym_d      = cur_sym_q;
    fsk_d          = fsk_q;
    underrun_d     = underrun_q;
    busy_d         = busy_q;
    set_underrun_c = 1'b0;

    if (!enable) begin
      // Disabling drops any in-flight symbol without flagging underrun.
      state_d = ST_IDLE;
      sc_d    = '0;
      hc_d    = '0;
      fsk_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sc_d  = '0;
          hc_d  = '0;
          fsk_d = 1'b0;
          if (accept_c) begin
            cur_sym_d = sym_if.sym_data;
            state_d   = ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          // >= so a switch to a shorter tone with hc already past it toggles at once.
          if (hc_q >= half_lim_c) begin
            hc_d  = '0;
            fsk_d = ~fsk_q;
          end else begin
            hc_d = hc_q + CNT_W'(1);
          end

          if (sym_last_c) begin
            sc_d = '0;
            if (accept_c) begin
              cur_sym_d = sym_if.sym_data;
            end else begin
              state_d        = ST_IDLE;
              hc_d           = '0;
              fsk_d          = 1'b0;
              set_underrun_c = 1'b1;
            end
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          sc_d    = '0;
          hc_d    = '0;
          fsk_d   = 1'b0;
        end
      endcase
    end

    // A new underrun event wins over a same-cycle clear.
    if (set_underrun_c) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end

    busy_d = (state_d == ST_ACTIVE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      state_q    <= ST_IDLE;
      sc_q       <= '0;
      hc_q       <= '0;
      cur_sym_q  <= '0;
      fsk_q      <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      hc_q       <= hc_d;
      cur_sym_q  <= cur_sym_d;
      fsk_q      <= fsk_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign fsk_output = fsk_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;

endmodule
